// File: rtl/wb_reg_file.sv
// wb_reg_file: write-back source mux, register file with write-through bypass, and last-write forward record
//   clk, rst_n                  : clock, asynchronous active-low reset
//   write_back_mux_sel_in       : 0 selects alu_data_in, 1 selects mem_data_in
//   alu_data_in, mem_data_in    : write-back candidates
//   reg_wr_en_in, reg_wr_addr_in: commit request and destination (r0 writes dropped)
//   rd_addr_a/b_in, rd_data_a/b_out : combinational read ports with bypass
//   wb_data_out                 : selected write-back value
//   fwd_en/addr/data_out        : registered record of the previous edge's write
module wb_reg_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_back_mux_sel_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic                      reg_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b_in,
    output logic [DATA_WIDTH-1:0]     rd_data_a_out,
    output logic [DATA_WIDTH-1:0]     rd_data_b_out,
    output logic [DATA_WIDTH-1:0]     wb_data_out,
    output logic                      fwd_en_out,
    output logic [REG_ADDR_WIDTH-1:0] fwd_addr_out,
    output logic [DATA_WIDTH-1:0]     fwd_data_out
);
    localparam int DEPTH = 1 << REG_ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wr_ok;
    logic                  hit_a;
    logic                  hit_b;
    assign wb_data     = write_back_mux_sel_in ? mem_data_in : alu_data_in;
    assign wb_data_out = wb_data;
    assign wr_ok       = reg_wr_en_in && (reg_wr_addr_in != '0);
    // Hit flags depend only on addresses/enable so they stay off the data-select path
    assign hit_a = reg_wr_en_in && (reg_wr_addr_in == rd_addr_a_in);
    assign hit_b = reg_wr_en_in && (reg_wr_addr_in == rd_addr_b_in);
    always_comb begin
        rd_data_a_out = (rd_addr_a_in == '0) ? '0 : hit_a ? wb_data : regs[rd_addr_a_in];
        rd_data_b_out = (rd_addr_b_in == '0) ? '0 : hit_b ? wb_data : regs[rd_addr_b_in];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[reg_wr_addr_in] <= wb_data;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_en_out   <= 1'b0;
            fwd_addr_out <= '0;
            fwd_data_out <= '0;
        end else begin
            fwd_en_out   <= wr_ok;
            fwd_addr_out <= reg_wr_addr_in;
            fwd_data_out <= wb_data;
        end
    end
endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: directed and randomized self-checking bench for wb_reg_file
module tb_wb_reg_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        en;
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [31:0] wb;
    logic        f_en;
    logic [4:0]  f_addr;
    logic [31:0] f_data;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m [32];
    logic [31:0] wbv;
    logic        m_fen;
    logic [4:0]  m_fa;
    logic [31:0] m_fd;

    always #5 clk = ~clk;

    wb_reg_file dut (
        .clk(clk), .rst_n(rst_n), .write_back_mux_sel_in(sel),
        .alu_data_in(alu), .mem_data_in(mem), .reg_wr_en_in(en),
        .reg_wr_addr_in(wa), .rd_addr_a_in(ra), .rd_addr_b_in(rb),
        .rd_data_a_out(rd_a), .rd_data_b_out(rd_b), .wb_data_out(wb),
        .fwd_en_out(f_en), .fwd_addr_out(f_addr), .fwd_data_out(f_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input logic [4:0] w, input logic [4:0] x, input logic [4:0] y);
        sel = s; alu = a; mem = d; en = e; wa = w; ra = x; rb = y;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (en && wa == addr) return wbv;
        return m[addr];
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        chk("rst_fwd_en", {31'd0, f_en}, 32'd0);
        chk("rst_fwd_addr", {27'd0, f_addr}, 32'd0);
        chk("rst_fwd_data", f_data, 32'd0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 9, 31);
        #1;
        chk("rst_rd_a", rd_a, 32'd0);
        chk("rst_rd_b", rd_b, 32'd0);

        // ALU-path write to r3
        drive(0, 32'h12345678, 32'h0, 1, 3, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 3, 3);
        #1;
        chk("alu_rd_a", rd_a, 32'h12345678);
        chk("alu_fwd_en", {31'd0, f_en}, 32'd1);
        chk("alu_fwd_addr", {27'd0, f_addr}, 32'd3);
        chk("alu_fwd_data", f_data, 32'h12345678);

        // Memory-path write to r3
        drive(1, 32'h1, 32'hCAFEF00D, 1, 3, 0, 0);
        #1;
        chk("mem_wb", wb, 32'hCAFEF00D);
        tick;
        drive(0, 0, 0, 0, 0, 3, 0);
        #1;
        chk("mem_rd_a", rd_a, 32'hCAFEF00D);
        chk("mem_fwd_data", f_data, 32'hCAFEF00D);

        // Bypass on r7
        drive(0, 32'h11111111, 0, 1, 7, 0, 0);
        tick;
        drive(0, 32'hA5A5A5A5, 0, 1, 7, 7, 7);
        #1;
        chk("byp_a", rd_a, 32'hA5A5A5A5);
        chk("byp_b", rd_b, 32'hA5A5A5A5);
        en = 1'b0;
        #1;
        chk("nobyp_a", rd_a, 32'h11111111);
        chk("nobyp_b", rd_b, 32'h11111111);
        tick;

        // r0 stays zero
        drive(0, 32'hFFFFFFFF, 0, 1, 0, 0, 0);
        #1;
        chk("r0_byp_a", rd_a, 32'd0);
        chk("r0_byp_b", rd_b, 32'd0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_after", rd_a, 32'd0);
        chk("r0_fwd_en", {31'd0, f_en}, 32'd0);
        chk("r0_fwd_data", f_data, 32'hFFFFFFFF);

        // Back-to-back writes
        drive(0, 32'd1, 0, 1, 1, 0, 0);
        tick;
        chk("b2b1_fwd_addr", {27'd0, f_addr}, 32'd1);
        chk("b2b1_fwd_data", f_data, 32'd1);
        drive(0, 32'd2, 0, 1, 1, 0, 0);
        tick;
        chk("b2b2_fwd_addr", {27'd0, f_addr}, 32'd1);
        chk("b2b2_fwd_data", f_data, 32'd2);
        drive(0, 32'd3, 0, 1, 2, 0, 0);
        tick;
        chk("b2b3_fwd_addr", {27'd0, f_addr}, 32'd2);
        chk("b2b3_fwd_data", f_data, 32'd3);
        chk("b2b3_fwd_en", {31'd0, f_en}, 32'd1);
        drive(0, 0, 0, 0, 0, 1, 2);
        #1;
        chk("b2b_r1", rd_a, 32'd2);
        chk("b2b_r2", rd_b, 32'd3);

        // Mid-cycle asynchronous reset
        drive(0, 32'hDEADBEEF, 0, 1, 5, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 5, 5);
        #1;
        chk("pre_rst_r5", rd_a, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_r5", rd_a, 32'd0);
        chk("async_rst_fwd_en", {31'd0, f_en}, 32'd0);
        chk("async_rst_fwd_addr", {27'd0, f_addr}, 32'd0);
        drive(0, 32'h66, 0, 1, 6, 6, 0);
        #1;
        chk("rst_bypass", rd_a, 32'h66);
        tick;
        en = 1'b0;
        #1;
        chk("rst_no_commit", rd_a, 32'd0);
        chk("rst_fwd_data_hold", f_data, 32'd0);
        rst_n = 1'b1;

        // Randomized run against a reference model
        for (int i = 0; i < 32; i++) m[i] = '0;
        for (int c = 0; c < 1000; c++) begin
            sel = 1'($urandom);
            alu = $urandom;
            mem = $urandom;
            en  = 1'($urandom);
            wa  = 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            wbv = sel ? mem : alu;
            #1;
            chk("rnd_wb", wb, wbv);
            chk("rnd_rd_a", rd_a, exp_rd(ra));
            chk("rnd_rd_b", rd_b, exp_rd(rb));
            m_fen = en && (wa != 5'd0);
            m_fa  = wa;
            m_fd  = wbv;
            if (m_fen) m[wa] = wbv;
            tick;
            chk("rnd_fwd_en", {31'd0, f_en}, {31'd0, m_fen});
            chk("rnd_fwd_addr", {27'd0, f_addr}, {27'd0, m_fa});
            chk("rnd_fwd_data", f_data, m_fd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
